// File: rtl/hwacc_icm_lookup_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hwacc_icm_lookup_arbiter_pkg
//  Brief    : Shared default parameters and helpers for the ICM lookup arbiter
//  Revision : 1.0 - initial release
// ============================================================================
package hwacc_icm_lookup_arbiter_pkg;

  localparam int c_DEF_REQ_NUM             = 4;
  localparam int c_DEF_REQ_NUM_LOG         = 2;
  localparam int c_DEF_ICM_ENTRY_NUM_LOG   = 10;
  localparam int c_DEF_ICM_ADDR_WIDTH      = 64;
  localparam int c_DEF_PHYSICAL_ADDR_WIDTH = 64;
  localparam int c_DEF_OUTSTANDING         = 4;
  localparam int c_DEF_OUTSTANDING_LOG     = 2;

  // Next round-robin start position after thread `id` wins (wraps at n-1).
  function automatic int rr_next(input int id, input int n);
    return (id >= n - 1) ? 0 : id + 1;
  endfunction

endpackage : hwacc_icm_lookup_arbiter_pkg
`default_nettype wire

// File: rtl/hwacc_icm_lookup_arbiter_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : hwacc_icm_lookup_arbiter_tag_fifo
//  Brief    : In-order tag FIFO holding the thread ID of every issued lookup
//             until its mapping response returns.
//  Revision : 1.0 - initial release
// ============================================================================
module hwacc_icm_lookup_arbiter_tag_fifo
  import hwacc_icm_lookup_arbiter_pkg::*;
#(
  parameter int WIDTH     = c_DEF_REQ_NUM_LOG,
  parameter int DEPTH     = c_DEF_OUTSTANDING,
  parameter int DEPTH_LOG = c_DEF_OUTSTANDING_LOG
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     pop_data,
  output logic                 full,
  output logic                 empty,
  output logic [DEPTH_LOG:0]   count
);

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [DEPTH_LOG-1:0] r_wr_ptr;
  logic [DEPTH_LOG-1:0] r_rd_ptr;
  logic [DEPTH_LOG:0]   r_count;
  logic                 w_do_push;
  logic                 w_do_pop;

  assign full      = (r_count == (DEPTH_LOG + 1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign pop_data  = r_mem[r_rd_ptr];
  // Guard against overflow/underflow locally so the pointers never corrupt.
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

  // Tag storage; contents are only meaningful while the entry is occupied.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule : hwacc_icm_lookup_arbiter_tag_fifo
`default_nettype wire

// File: rtl/hwacc_icm_lookup_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : hwacc_icm_lookup_arbiter
//  Brief    : Shares one ICM mapping-lookup channel among REQ_NUM threads.
//             Round-robin grant with lock-until-accept, in-order tag FIFO,
//             zero-latency response routing to the FIFO-head requester.
//  Revision : 1.0 - initial release
// ============================================================================
module hwacc_icm_lookup_arbiter
  import hwacc_icm_lookup_arbiter_pkg::*;
#(
  parameter int REQ_NUM             = c_DEF_REQ_NUM,
  parameter int REQ_NUM_LOG         = c_DEF_REQ_NUM_LOG,
  parameter int ICM_ENTRY_NUM_LOG   = c_DEF_ICM_ENTRY_NUM_LOG,
  parameter int ICM_ADDR_WIDTH      = c_DEF_ICM_ADDR_WIDTH,
  parameter int PHYSICAL_ADDR_WIDTH = c_DEF_PHYSICAL_ADDR_WIDTH,
  parameter int OUTSTANDING         = c_DEF_OUTSTANDING,
  parameter int OUTSTANDING_LOG     = c_DEF_OUTSTANDING_LOG
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [REQ_NUM-1:0]                   req_lookup_valid,
  input  logic [REQ_NUM*ICM_ENTRY_NUM_LOG-1:0] req_lookup_head,
  output logic [REQ_NUM-1:0]                   req_lookup_ready,
  output logic [REQ_NUM-1:0]                   req_rsp_valid,
  output logic [ICM_ADDR_WIDTH-1:0]            req_rsp_icm_addr,
  output logic [PHYSICAL_ADDR_WIDTH-1:0]       req_rsp_phy_addr,
  input  logic [REQ_NUM-1:0]                   req_rsp_ready,
  output logic                                 icm_mapping_lookup_valid,
  output logic [ICM_ENTRY_NUM_LOG-1:0]         icm_mapping_lookup_head,
  input  logic                                 icm_mapping_lookup_ready,
  input  logic                                 icm_mapping_rsp_valid,
  input  logic [ICM_ADDR_WIDTH-1:0]            icm_mapping_rsp_icm_addr,
  input  logic [PHYSICAL_ADDR_WIDTH-1:0]       icm_mapping_rsp_phy_addr,
  output logic                                 icm_mapping_rsp_ready,
  output logic [OUTSTANDING_LOG:0]             outstanding_cnt,
  output logic                                 err_unexpected_rsp
);

  logic [REQ_NUM_LOG-1:0] r_rr_ptr;
  logic                   r_lock;
  logic [REQ_NUM_LOG-1:0] r_locked_id;
  logic                   r_err;

  logic [REQ_NUM_LOG-1:0] w_grant;
  logic                   w_grant_valid;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [REQ_NUM_LOG-1:0] w_head_id;
  logic                   w_lookup_hs;
  logic                   w_rsp_route;
  logic                   w_rsp_hs;

  // Grant selection: a locked grant is held while its requester still presents
  // valid; otherwise scan from the round-robin pointer (lowest offset wins).
  always_comb begin
    w_grant       = '0;
    w_grant_valid = 1'b0;
    if (r_lock && req_lookup_valid[r_locked_id]) begin
      w_grant       = r_locked_id;
      w_grant_valid = 1'b1;
    end else begin
      for (int k = REQ_NUM - 1; k >= 0; k--) begin
        if (req_lookup_valid[(int'(r_rr_ptr) + k) % REQ_NUM]) begin
          w_grant       = REQ_NUM_LOG'((int'(r_rr_ptr) + k) % REQ_NUM);
          w_grant_valid = 1'b1;
        end
      end
    end
  end

  assign icm_mapping_lookup_valid = w_grant_valid && !w_fifo_full;
  assign icm_mapping_lookup_head  = icm_mapping_lookup_valid
                                  ? req_lookup_head[int'(w_grant)*ICM_ENTRY_NUM_LOG +: ICM_ENTRY_NUM_LOG]
                                  : '0;
  assign w_lookup_hs = icm_mapping_lookup_valid && icm_mapping_lookup_ready;

  generate
    for (genvar i = 0; i < REQ_NUM; i++) begin : g_lookup_ready
      assign req_lookup_ready[i] = w_lookup_hs && (w_grant == REQ_NUM_LOG'(i));
    end
  endgenerate

  // Round-robin pointer advances past the winner on accept; an offered but
  // unaccepted lookup locks the grant so the downstream sees a stable request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_lock      <= 1'b0;
      r_locked_id <= '0;
    end else if (w_lookup_hs) begin
      r_rr_ptr <= REQ_NUM_LOG'(rr_next(int'(w_grant), REQ_NUM));
      r_lock   <= 1'b0;
    end else if (icm_mapping_lookup_valid) begin
      r_lock      <= 1'b1;
      r_locked_id <= w_grant;
    end else if (!w_fifo_full) begin
      r_lock <= 1'b0;
    end
  end

  hwacc_icm_lookup_arbiter_tag_fifo #(
    .WIDTH     (REQ_NUM_LOG),
    .DEPTH     (OUTSTANDING),
    .DEPTH_LOG (OUTSTANDING_LOG)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_lookup_hs),
    .push_data (w_grant),
    .pop       (w_rsp_hs),
    .pop_data  (w_head_id),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (outstanding_cnt)
  );

  // Response demux: the oldest outstanding tag owns every returning response.
  assign w_rsp_route           = icm_mapping_rsp_valid && !w_fifo_empty;
  assign icm_mapping_rsp_ready = !w_fifo_empty && req_rsp_ready[w_head_id];
  assign w_rsp_hs              = icm_mapping_rsp_valid && icm_mapping_rsp_ready;
  assign req_rsp_valid         = w_rsp_route ? (REQ_NUM'(1) << w_head_id) : '0;
  assign req_rsp_icm_addr      = w_rsp_route ? icm_mapping_rsp_icm_addr : '0;
  assign req_rsp_phy_addr      = w_rsp_route ? icm_mapping_rsp_phy_addr : '0;

  // Sticky flag for a response that has no matching outstanding lookup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        r_err <= 1'b0;
    else if (icm_mapping_rsp_valid && w_fifo_empty) r_err <= 1'b1;
  end

  assign err_unexpected_rsp = r_err;

endmodule : hwacc_icm_lookup_arbiter
`default_nettype wire

// File: tb/tb_hwacc_icm_lookup_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hwacc_icm_lookup_arbiter
//  Brief    : Self-checking bench: directed scenarios plus randomized traffic
//             against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hwacc_icm_lookup_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_lookup_valid;
  logic [39:0] req_lookup_head;
  logic [3:0]  req_lookup_ready;
  logic [3:0]  req_rsp_valid;
  logic [63:0] req_rsp_icm_addr;
  logic [63:0] req_rsp_phy_addr;
  logic [3:0]  req_rsp_ready;
  logic        icm_mapping_lookup_valid;
  logic [9:0]  icm_mapping_lookup_head;
  logic        icm_mapping_lookup_ready;
  logic        icm_mapping_rsp_valid;
  logic [63:0] icm_mapping_rsp_icm_addr;
  logic [63:0] icm_mapping_rsp_phy_addr;
  logic        icm_mapping_rsp_ready;
  logic [2:0]  outstanding_cnt;
  logic        err_unexpected_rsp;

  int checks = 0;
  int errors = 0;

  // Reference model state: tags in issue order, round-robin start, lock.
  int   q[$];
  int   m_rr;
  bit   m_lock;
  int   m_lid;
  bit   m_err;
  logic [3:0] last_rdy;
  bit   pend [4];

  hwacc_icm_lookup_arbiter dut (
    .clk                      (clk),
    .rst                      (rst),
    .req_lookup_valid         (req_lookup_valid),
    .req_lookup_head          (req_lookup_head),
    .req_lookup_ready         (req_lookup_ready),
    .req_rsp_valid            (req_rsp_valid),
    .req_rsp_icm_addr         (req_rsp_icm_addr),
    .req_rsp_phy_addr         (req_rsp_phy_addr),
    .req_rsp_ready            (req_rsp_ready),
    .icm_mapping_lookup_valid (icm_mapping_lookup_valid),
    .icm_mapping_lookup_head  (icm_mapping_lookup_head),
    .icm_mapping_lookup_ready (icm_mapping_lookup_ready),
    .icm_mapping_rsp_valid    (icm_mapping_rsp_valid),
    .icm_mapping_rsp_icm_addr (icm_mapping_rsp_icm_addr),
    .icm_mapping_rsp_phy_addr (icm_mapping_rsp_phy_addr),
    .icm_mapping_rsp_ready    (icm_mapping_rsp_ready),
    .outstanding_cnt          (outstanding_cnt),
    .err_unexpected_rsp       (err_unexpected_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    req_lookup_valid         = '0;
    req_lookup_head          = '0;
    req_rsp_ready            = '0;
    icm_mapping_lookup_ready = 1'b0;
    icm_mapping_rsp_valid    = 1'b0;
    icm_mapping_rsp_icm_addr = '0;
    icm_mapping_rsp_phy_addr = '0;
  endtask

  task automatic model_reset();
    q.delete();
    m_rr   = 0;
    m_lock = 0;
    m_lid  = 0;
    m_err  = 0;
    for (int i = 0; i < 4; i++) pend[i] = 0;
  endtask

  // Reset pulse with inputs idle; checks the reset-state outputs.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("rst_lookup_valid", 64'(icm_mapping_lookup_valid), 0);
    chk("rst_lookup_head",  64'(icm_mapping_lookup_head), 0);
    chk("rst_req_rdy",      64'(req_lookup_ready), 0);
    chk("rst_rsp_valid",    64'(req_rsp_valid), 0);
    chk("rst_rsp_ready",    64'(icm_mapping_rsp_ready), 0);
    chk("rst_cnt",          64'(outstanding_cnt), 0);
    chk("rst_err",          64'(err_unexpected_rsp), 0);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // One clock: compare every output with the model, then advance the model.
  task automatic cycle();
    int   g;
    bit   gv;
    bit   full;
    logic e_lv, e_rsprdy;
    logic [9:0]  e_head;
    logic [3:0]  e_rdy, e_rspv;
    logic [63:0] e_icm, e_phy;
    #1;
    full = (q.size() >= 4);
    gv = 0;
    g  = 0;
    if (m_lock && req_lookup_valid[m_lid]) begin
      g  = m_lid;
      gv = 1;
    end else begin
      for (int k = 0; k < 4; k++)
        if (!gv && req_lookup_valid[(m_rr + k) % 4]) begin
          g  = (m_rr + k) % 4;
          gv = 1;
        end
    end
    e_lv   = gv && !full;
    e_head = e_lv ? req_lookup_head[g*10 +: 10] : 10'd0;
    e_rdy  = (e_lv && icm_mapping_lookup_ready) ? 4'(1 << g) : 4'd0;
    e_rspv = '0; e_rsprdy = 0; e_icm = '0; e_phy = '0;
    if (q.size() > 0) begin
      e_rsprdy = req_rsp_ready[q[0]];
      if (icm_mapping_rsp_valid) begin
        e_rspv = 4'(1 << q[0]);
        e_icm  = icm_mapping_rsp_icm_addr;
        e_phy  = icm_mapping_rsp_phy_addr;
      end
    end
    chk("lookup_valid", 64'(icm_mapping_lookup_valid), 64'(e_lv));
    chk("lookup_head",  64'(icm_mapping_lookup_head), 64'(e_head));
    chk("req_rdy",      64'(req_lookup_ready), 64'(e_rdy));
    chk("rsp_valid",    64'(req_rsp_valid), 64'(e_rspv));
    chk("rsp_ready",    64'(icm_mapping_rsp_ready), 64'(e_rsprdy));
    chk("rsp_icm",      req_rsp_icm_addr, e_icm);
    chk("rsp_phy",      req_rsp_phy_addr, e_phy);
    chk("cnt",          64'(outstanding_cnt), 64'(q.size()));
    chk("err",          64'(err_unexpected_rsp), 64'(m_err));
    last_rdy = e_rdy;
    @(posedge clk);
    if (icm_mapping_rsp_valid && q.size() == 0) m_err = 1;
    if (icm_mapping_rsp_valid && e_rsprdy) void'(q.pop_front());
    if (e_lv && icm_mapping_lookup_ready) begin
      q.push_back(g);
      m_rr   = (g + 1) % 4;
      m_lock = 0;
    end else if (e_lv) begin
      m_lock = 1;
      m_lid  = g;
    end else if (!full) begin
      m_lock = 0;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    last_rdy = '0;
    clear_inputs();
    model_reset();
    do_reset();

    // T1: single requester, lookup passes through the same cycle; rsp routed.
    req_lookup_valid = 4'b0100;
    req_lookup_head[20 +: 10] = 10'h05A;
    icm_mapping_lookup_ready = 1'b1;
    #1;
    chk("t1_head", 64'(icm_mapping_lookup_head), 64'h05A);
    chk("t1_rdy",  64'(req_lookup_ready), 64'b0100);
    cycle();
    req_lookup_valid = '0;
    icm_mapping_rsp_valid    = 1'b1;
    icm_mapping_rsp_icm_addr = 64'h1000;
    icm_mapping_rsp_phy_addr = 64'hABC000;
    req_rsp_ready = 4'b1111;
    #1;
    chk("t1_rspv", 64'(req_rsp_valid), 64'b0100);
    chk("t1_phy",  req_rsp_phy_addr, 64'hABC000);
    cycle();

    // T2: all threads requesting, responses stalled -> 0,1,2,3 then full.
    do_reset();
    req_lookup_valid = 4'hF;
    for (int i = 0; i < 4; i++) req_lookup_head[i*10 +: 10] = 10'(16'h100 + i);
    icm_mapping_lookup_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_grant", 64'(req_lookup_ready), 64'(1 << i));
      cycle();
    end
    #1;
    chk("t2_full_valid", 64'(icm_mapping_lookup_valid), 0);
    chk("t2_cnt",        64'(outstanding_cnt), 4);
    cycle();

    // T3: downstream back-pressure holds thread 1 despite thread 0 arriving.
    do_reset();
    req_lookup_valid = 4'b0010;
    req_lookup_head = {10'h333, 10'h222, 10'h111, 10'h000};
    icm_mapping_lookup_ready = 1'b0;
    cycle();
    req_lookup_valid = 4'b0011;
    cycle();
    cycle();
    #1;
    chk("t3_hold_head", 64'(icm_mapping_lookup_head), 64'h111);
    icm_mapping_lookup_ready = 1'b1;
    cycle();
    req_lookup_valid = 4'b0001;
    #1;
    chk("t3_next_rdy", 64'(req_lookup_ready), 64'b0001);
    cycle();

    // T4: in-order delivery with a stalled first consumer.
    do_reset();
    icm_mapping_lookup_ready = 1'b1;
    req_lookup_valid = 4'b0001; cycle();
    req_lookup_valid = 4'b1000; cycle();
    req_lookup_valid = 4'b0000;
    icm_mapping_rsp_valid    = 1'b1;
    icm_mapping_rsp_icm_addr = 64'hAAAA;
    icm_mapping_rsp_phy_addr = 64'hA0A0;
    req_rsp_ready = 4'b1110;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t4_stall_rdy", 64'(icm_mapping_rsp_ready), 0);
      chk("t4_stall_v",   64'(req_rsp_valid), 64'b0001);
      cycle();
    end
    req_rsp_ready = 4'b1111;
    cycle();
    icm_mapping_rsp_icm_addr = 64'hBBBB;
    icm_mapping_rsp_phy_addr = 64'hB0B0;
    #1;
    chk("t4_b_route", 64'(req_rsp_valid), 64'b1000);
    cycle();
    icm_mapping_rsp_valid = 1'b0;

    // T5: full FIFO with a pop and a pending request in the same cycle.
    do_reset();
    icm_mapping_lookup_ready = 1'b1;
    req_lookup_valid = 4'hF;
    for (int i = 0; i < 4; i++) cycle();
    icm_mapping_rsp_valid = 1'b1;
    icm_mapping_rsp_icm_addr = 64'h55;
    req_rsp_ready = 4'hF;
    #1;
    chk("t5_no_push", 64'(icm_mapping_lookup_valid), 0);
    chk("t5_pop",     64'(icm_mapping_rsp_ready), 1);
    cycle();
    icm_mapping_rsp_valid = 1'b0;
    #1;
    chk("t5_cnt3",  64'(outstanding_cnt), 3);
    chk("t5_valid", 64'(icm_mapping_lookup_valid), 1);
    cycle();
    chk("t5_cnt4",  64'(outstanding_cnt), 4);

    // T6: response with nothing outstanding, then reset during traffic.
    do_reset();
    icm_mapping_rsp_valid = 1'b1;
    req_rsp_ready = 4'hF;
    #1;
    chk("t6_rdy0", 64'(icm_mapping_rsp_ready), 0);
    cycle();
    icm_mapping_rsp_valid = 1'b0;
    cycle();
    chk("t6_sticky", 64'(err_unexpected_rsp), 1);
    req_lookup_valid = 4'b0110;
    icm_mapping_lookup_ready = 1'b1;
    cycle();
    cycle();
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_rst_cnt", 64'(outstanding_cnt), 0);
    chk("t6_rst_err", 64'(err_unexpected_rsp), 0);
    clear_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic; requesters hold valid/head stable until accepted.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1;
          req_lookup_head[i*10 +: 10] = 10'($urandom);
        end
        req_lookup_valid[i] = pend[i];
      end
      icm_mapping_lookup_ready = ($urandom_range(0, 3) != 0);
      icm_mapping_rsp_valid    = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      icm_mapping_rsp_icm_addr = {$urandom, $urandom};
      icm_mapping_rsp_phy_addr = {$urandom, $urandom};
      req_rsp_ready            = 4'($urandom);
      cycle();
      for (int i = 0; i < 4; i++) if (last_rdy[i]) pend[i] = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_hwacc_icm_lookup_arbiter
`default_nettype wire
